axil_ipif_bridge: RTL and testbench

Parametrised AXI4-Lite slave to IPIF register bridge. It connects one AXI-Lite master port to a user register file through the `bus2ip_*` / `ip2bus_*` strobe-and-acknowledge interface. Compared with the fixed 4-register bridge, it adds:
- a configurable register count;
- byte enables;
- B and R response channels with OKAY/SLVERR/DECERR;
- independent AW/W acceptance;
- fair read/write arbitration;
- an optional acknowledge timeout.

---
 rtl/axil_ipif_pkg.sv | 29 ++
 rtl/ipif_addr_decode.sv | 28 ++
 rtl/axil_ipif_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_axil_ipif_bridge.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_ipif_pkg.sv
// Shared response codes, FSM state encodings and helpers for the AXI-Lite to IPIF bridge.
package axil_ipif_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE = 2'd0;
  localparam w_state_t W_WAIT = 2'd1;
  localparam w_state_t W_REQ  = 2'd2;
  localparam w_state_t W_RESP = 2'd3;

  typedef logic [1:0] r_state_t;
  localparam r_state_t R_IDLE = 2'd0;
  localparam r_state_t R_WAIT = 2'd1;
  localparam r_state_t R_REQ  = 2'd2;
  localparam r_state_t R_RESP = 2'd3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ipif_addr_decode.sv
// Byte address to one-hot register chip-enable, flagging addresses beyond the register file.
module ipif_addr_decode
  import axil_ipif_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 4
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] ce,
  output logic                out_of_range
);

  localparam int IDX_W = clog2(NUM_REGS);

  logic [IDX_W-1:0] idx;
  logic             unused_byte_lane;

  assign idx              = addr[IDX_W+1:2];
  assign out_of_range     = |addr[ADDR_W-1:IDX_W+2];
  assign unused_byte_lane = ^addr[1:0];

  always_comb begin
    // NOTE: default assignment first so no latch is inferred on the unselected bits.
    ce = '0;
    if (!out_of_range) ce[idx] = 1'b1;
  end

endmodule

// File: rtl/axil_ipif_bridge.sv
// AXI4-Lite slave to IPIF strobe/ack bridge with independent AW/W capture and fair R/W arbitration.
// Optional acknowledge timeout enabled by defining AXIL_IPIF_TIMEOUT_EN.
module axil_ipif_bridge
  import axil_ipif_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_REGS    = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic                       WVALID,
  output logic                       WREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [DATA_W/8-1:0]        WSTRB,
  output logic                       BVALID,
  input  logic                       BREADY,
  output logic [1:0]                 BRESP,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic                       bus2ip_clk,
  output logic [ADDR_W-1:0]          bus2ip_addr,
  output logic [DATA_W-1:0]          bus2ip_data,
  output logic [DATA_W/8-1:0]        bus2ip_be,
  output logic [NUM_REGS-1:0]        bus2ip_wrce,
  output logic [NUM_REGS-1:0]        bus2ip_rdce,
  input  logic [NUM_REGS*DATA_W-1:0] ip2bus_data,
  input  logic                       ip2bus_wrack,
  input  logic                       ip2bus_rdack,
  input  logic                       ip2bus_error
);

  localparam int IDX_W = clog2(NUM_REGS);

  w_state_t            w_state;
  r_state_t            r_state;
  logic                aw_held, w_held, w_oor_q, r_oor_q, prio_w;
  logic [ADDR_W-1:0]   aw_addr_q, ar_addr_q, aw_addr_eff, ar_addr_eff;
  logic [DATA_W-1:0]   w_data_q, rd_slice;
  logic [DATA_W/8-1:0] w_be_q;
  logic                aw_hs, w_hs, ar_hs, wr_req, rd_req, busy, grant_w, grant_r;
  logic [NUM_REGS-1:0] w_ce, r_ce;
  logic                w_oor, r_oor, w_done, r_done, timeout;
  logic [1:0]          w_resp, r_resp;
  logic [IDX_W-1:0]    rd_idx;

  assign bus2ip_clk = ACLK;

  assign AWREADY = !ARESET && (w_state == W_IDLE) && !aw_held;
  assign WREADY  = !ARESET && (w_state == W_IDLE) && !w_held;
  assign ARREADY = !ARESET && (r_state == R_IDLE);

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // A request completing this edge competes immediately, so the strobe follows the handshake by one cycle.
  assign wr_req  = (w_state == W_WAIT) ||
                   ((w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs));
  assign rd_req  = (r_state == R_WAIT) || ar_hs;
  assign busy    = (w_state == W_REQ) || (r_state == R_REQ);
  assign grant_r = rd_req && !busy && (!wr_req || !prio_w);
  assign grant_w = wr_req && !busy && (!rd_req || prio_w);

  assign aw_addr_eff = aw_held ? aw_addr_q : AWADDR;
  assign ar_addr_eff = (r_state == R_WAIT) ? ar_addr_q : ARADDR;

  ipif_addr_decode #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_aw_decode (
    .addr(aw_addr_eff), .ce(w_ce), .out_of_range(w_oor)
  );
  ipif_addr_decode #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_ar_decode (
    .addr(ar_addr_eff), .ce(r_ce), .out_of_range(r_oor)
  );

  assign w_done = (w_state == W_REQ) && (w_oor_q || ip2bus_wrack || timeout);
  assign r_done = (r_state == R_REQ) && (r_oor_q || ip2bus_rdack || timeout);
  assign w_resp = w_oor_q ? RESP_DECERR :
                  (ip2bus_wrack && !ip2bus_error) ? RESP_OKAY : RESP_SLVERR;
  assign r_resp = r_oor_q ? RESP_DECERR :
                  (ip2bus_rdack && !ip2bus_error) ? RESP_OKAY : RESP_SLVERR;

  assign rd_idx = bus2ip_addr[IDX_W+1:2];
  always_comb begin
    rd_slice = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_slice = ip2bus_data[DATA_W*i +: DATA_W];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state     <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_be_q      <= '0;
      w_oor_q     <= 1'b0;
      bus2ip_wrce <= '0;
      BVALID      <= 1'b0;
      BRESP       <= RESP_OKAY;
    end else begin
      // NOTE: non-blocking assignments so every sequential block sees pre-edge values.
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_be_q   <= WSTRB;
      end
      case (w_state)
        W_IDLE, W_WAIT: begin
          if (grant_w) begin
            w_state     <= W_REQ;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            bus2ip_wrce <= w_ce;
            w_oor_q     <= w_oor;
          end else if (wr_req) begin
            w_state <= W_WAIT;
          end
        end
        W_REQ: if (w_done) begin
          w_state     <= W_RESP;
          bus2ip_wrce <= '0;
          BVALID      <= 1'b1;
          BRESP       <= w_resp;
        end
        W_RESP: if (BREADY) begin
          w_state <= W_IDLE;
          BVALID  <= 1'b0;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= R_IDLE;
      ar_addr_q   <= '0;
      r_oor_q     <= 1'b0;
      bus2ip_rdce <= '0;
      RVALID      <= 1'b0;
      RRESP       <= RESP_OKAY;
      RDATA       <= '0;
    end else begin
      if (ar_hs) ar_addr_q <= ARADDR;
      case (r_state)
        R_IDLE, R_WAIT: begin
          if (grant_r) begin
            r_state     <= R_REQ;
            bus2ip_rdce <= r_ce;
            r_oor_q     <= r_oor;
          end else if (rd_req) begin
            r_state <= R_WAIT;
          end
        end
        R_REQ: if (r_done) begin
          r_state     <= R_RESP;
          bus2ip_rdce <= '0;
          RVALID      <= 1'b1;
          RRESP       <= r_resp;
          RDATA       <= (r_resp == RESP_OKAY) ? rd_slice : '0;
        end
        R_RESP: if (RREADY) begin
          r_state <= R_IDLE;
          RVALID  <= 1'b0;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bus2ip_addr <= '0;
      bus2ip_data <= '0;
      bus2ip_be   <= '0;
      prio_w      <= 1'b0;
    end else begin
      if (grant_w) begin
        bus2ip_addr <= aw_addr_eff;
        bus2ip_data <= w_held ? w_data_q : WDATA;
        bus2ip_be   <= w_held ? w_be_q : WSTRB;
      end else if (grant_r) begin
        bus2ip_addr <= ar_addr_eff;
        bus2ip_be   <= '0;
      end
      if (wr_req && rd_req && !busy) prio_w <= !prio_w;
    end
  end

`ifdef AXIL_IPIF_TIMEOUT_EN
  logic [7:0] to_cnt;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)     to_cnt <= '0;
    else if (!busy) to_cnt <= '0;
    else            to_cnt <= to_cnt + 8'd1;
  end

  assign timeout = busy && (to_cnt == 8'(TIMEOUT_CYC - 1));
`else
  logic [7:0] unused_timeout_cyc;

  assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_axil_ipif_bridge.sv
// Directed self-checking bench for axil_ipif_bridge with NUM_REGS=8 and a scripted IPIF responder.
module tb_axil_ipif_bridge;

  localparam int         NUM_REGS = 8;
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;
  localparam logic [1:0] DECERR   = 2'b11;

  logic                     ACLK = 1'b0;
  logic                     ARESET;
  logic                     AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic                     ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]              AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]               WSTRB;
  logic [1:0]               BRESP, RRESP;
  logic                     bus2ip_clk;
  logic [31:0]              bus2ip_addr, bus2ip_data;
  logic [3:0]               bus2ip_be;
  logic [NUM_REGS-1:0]      bus2ip_wrce, bus2ip_rdce;
  logic [NUM_REGS*32-1:0]   ip2bus_data;
  logic                     ip2bus_wrack, ip2bus_rdack, ip2bus_error;

  int checks = 0;
  int failures = 0;

  // Responder controls (main process) and monitor observations (monitor process).
  int             ack_delay = 0;
  logic           ack_err = 1'b0;
  logic           stray_acks = 1'b0;
  int             wr_cycles = 0, rd_cycles = 0;
  logic [7:0]     last_wrce = '0, last_rdce = '0;
  logic [3:0]     last_be = '0, last_rd_be = '0;
  logic [31:0]    last_data = '0, last_addr = '0;
  logic [7:0]     grant_log[$];

  always #5 ACLK = ~ACLK;

  axil_ipif_bridge #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(NUM_REGS), .TIMEOUT_CYC(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .bus2ip_clk(bus2ip_clk), .bus2ip_addr(bus2ip_addr), .bus2ip_data(bus2ip_data),
    .bus2ip_be(bus2ip_be), .bus2ip_wrce(bus2ip_wrce), .bus2ip_rdce(bus2ip_rdce),
    .ip2bus_data(ip2bus_data), .ip2bus_wrack(ip2bus_wrack), .ip2bus_rdack(ip2bus_rdack),
    .ip2bus_error(ip2bus_error)
  );

  function automatic logic [31:0] reg_val(input int k);
    return (k == 2) ? 32'h1234_5678 : (32'hA5A5_0000 | 32'(k));
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor and IPIF responder: acks after ack_delay strobe cycles, evaluated away from the clock edge.
  initial begin
    int  strobe_cnt;
    logic prev_wr, prev_rd;
    strobe_cnt = 0; prev_wr = 1'b0; prev_rd = 1'b0;
    ip2bus_wrack = 1'b0; ip2bus_rdack = 1'b0; ip2bus_error = 1'b0;
    forever begin
      @(negedge ACLK);
      if (|bus2ip_wrce) begin
        wr_cycles++;
        last_wrce = bus2ip_wrce; last_be = bus2ip_be;
        last_data = bus2ip_data; last_addr = bus2ip_addr;
        if (!prev_wr) grant_log.push_back("W");
      end
      if (|bus2ip_rdce) begin
        rd_cycles++;
        last_rdce = bus2ip_rdce; last_rd_be = bus2ip_be; last_addr = bus2ip_addr;
        if (!prev_rd) grant_log.push_back("R");
      end
      prev_wr = |bus2ip_wrce;
      prev_rd = |bus2ip_rdce;
      if (stray_acks) begin
        ip2bus_wrack = 1'b1; ip2bus_rdack = 1'b1; ip2bus_error = 1'b0; strobe_cnt = 0;
      end else if (prev_wr || prev_rd) begin
        ip2bus_wrack = prev_wr && (strobe_cnt == ack_delay);
        ip2bus_rdack = prev_rd && (strobe_cnt == ack_delay);
        ip2bus_error = ack_err && (strobe_cnt == ack_delay);
        strobe_cnt++;
      end else begin
        ip2bus_wrack = 1'b0; ip2bus_rdack = 1'b0; ip2bus_error = 1'b0; strobe_cnt = 0;
      end
    end
  end

  // lat = cycles from the AW handshake edge to the first cycle BVALID is seen.
  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit w_first,
                           output int lat, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    if (w_first) begin
      n = 0;
      while (!WREADY && n < 100) begin @(negedge ACLK); n++; end
      @(negedge ACLK);
      WVALID = 1'b0;
    end
    AWADDR = addr; AWVALID = 1'b1;
    n = 0;
    while (!(AWREADY && (WREADY || !WVALID)) && n < 100) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    lat = 1;
    while (!BVALID && lat < 200) begin @(negedge ACLK); lat++; end
    check({tag, "_bvalid"}, BVALID, 1'b1);
    resp = BRESP;
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr, input int rdly,
                          output int lat, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 100) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    ARVALID = 1'b0;
    lat = 1;
    while (!RVALID && lat < 200) begin @(negedge ACLK); lat++; end
    repeat (rdly) @(negedge ACLK);
    check({tag, "_rvalid"}, RVALID, 1'b1);
    data = RDATA; resp = RRESP;
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat2, base_wr, base_rd, base_log;
    logic [1:0]  resp, resp2;
    logic [31:0] data;
    logic        rv_seen;

    ARESET = 1'b1;
    AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0; BREADY = 1'b0;
    ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) ip2bus_data[32*k +: 32] = reg_val(k);
    repeat (3) @(negedge ACLK);

    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_arready", ARREADY, 1'b0);
    check("rst_valids", {BVALID, RVALID}, 2'b00);
    check("rst_resps", {BRESP, RRESP}, 4'h0);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_addr", bus2ip_addr, 32'h0);
    check("rst_ce", {bus2ip_wrce, bus2ip_rdce}, 16'h0);
    check("rst_be", bus2ip_be, 4'h0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("idle_readys", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Write 0x14, W one cycle before AW, zero-wait ack.
    ack_delay = 0;
    base_wr = wr_cycles;
    axi_write("wr1", 32'h14, 32'hDEAD_BEEF, 4'b0101, 1'b1, lat, resp);
    check("wr1_wrce", last_wrce, 8'h20);
    check("wr1_be", last_be, 4'b0101);
    check("wr1_data", last_data, 32'hDEAD_BEEF);
    check("wr1_addr", last_addr, 32'h14);
    check("wr1_strobe_cycles", wr_cycles - base_wr, 1);
    check("wr1_latency", lat, 2);
    check("wr1_bresp", resp, OKAY);

    // Read reg2 with three wait cycles; RREADY held off to confirm the response stays put.
    ack_delay = 3;
    base_rd = rd_cycles;
    axi_read("rd2", 32'h08, 2, lat, data, resp);
    check("rd2_rdce", last_rdce, 8'h04);
    check("rd2_be", last_rd_be, 4'h0);
    check("rd2_strobe_cycles", rd_cycles - base_rd, 4);
    check("rd2_latency", lat, 5);
    check("rd2_rdata", data, 32'h1234_5678);
    check("rd2_rresp", resp, OKAY);
    ack_delay = 0;

    // Out-of-range read: no strobe, DECERR one cycle after grant.
    base_rd = rd_cycles;
    axi_read("rd_oor", 32'h40, 0, lat, data, resp);
    check("rd_oor_strobe_cycles", rd_cycles - base_rd, 0);
    check("rd_oor_latency", lat, 2);
    check("rd_oor_rresp", resp, DECERR);
    check("rd_oor_rdata", data, 32'h0);

    // Out-of-range write.
    base_wr = wr_cycles;
    axi_write("wr_oor", 32'h0000_0100, 32'h1, 4'hF, 1'b0, lat, resp);
    check("wr_oor_strobe_cycles", wr_cycles - base_wr, 0);
    check("wr_oor_bresp", resp, DECERR);

    // Slave error on write, AW and W together.
    ack_err = 1'b1;
    axi_write("wr_err", 32'h1C, 32'h0BAD_F00D, 4'hF, 1'b0, lat, resp);
    check("wr_err_bresp", resp, SLVERR);
    check("wr_err_wrce", last_wrce, 8'h80);
    ack_err = 1'b0;

    // Acks with no active strobe must be ignored.
    stray_acks = 1'b1;
    repeat (3) @(negedge ACLK);
    check("stray_valids", {BVALID, RVALID}, 2'b00);
    check("stray_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
    stray_acks = 1'b0;
    repeat (2) @(negedge ACLK);

    // Simultaneous requests: first grant alternates R, W, R, W.
    for (int k = 0; k < 4; k++) begin
      base_log = grant_log.size();
      fork
        axi_write($sformatf("arb%0d_w", k), 32'h0C, 32'h100 + 32'(k), 4'hF, 1'b0, lat, resp);
        axi_read($sformatf("arb%0d_r", k), 32'(4 * k), 0, lat2, data, resp2);
      join
      check($sformatf("arb%0d_first", k), grant_log[base_log], (k % 2 == 0) ? 8'h52 : 8'h57);
      check($sformatf("arb%0d_resps", k), {resp, resp2}, {OKAY, OKAY});
      check($sformatf("arb%0d_rdata", k), data, reg_val(k));
    end

    // Reset while a read strobe is active: the transaction is dropped.
    ack_delay = 1000;
    @(negedge ACLK);
    ARADDR = 32'h08; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    @(negedge ACLK);
    check("rst_mid_rdce_before", bus2ip_rdce, 8'h04);
    ARESET = 1'b1;
    RREADY = 1'b1;
    #1;
    check("rst_mid_rdce_cleared", bus2ip_rdce, 8'h00);
    check("rst_mid_arready_gated", ARREADY, 1'b0);
    @(negedge ACLK);
    ARESET = 1'b0;
    ack_delay = 0;
    rv_seen = 1'b0;
    repeat (5) begin
      @(negedge ACLK);
      if (RVALID) rv_seen = 1'b1;
    end
    check("rst_mid_no_rvalid", rv_seen, 1'b0);
    RREADY = 1'b0;
    axi_read("rd_after_rst", 32'h08, 0, lat, data, resp);
    check("rd_after_rst_rdata", data, 32'h1234_5678);
    check("rd_after_rst_rresp", resp, OKAY);

`ifdef AXIL_IPIF_TIMEOUT_EN
    // No ack: strobe drops after 16 cycles with SLVERR.
    ack_delay = 1000;
    base_rd = rd_cycles;
    axi_read("rd_to", 32'h0C, 0, lat, data, resp);
    check("rd_to_strobe_cycles", rd_cycles - base_rd, 16);
    check("rd_to_latency", lat, 17);
    check("rd_to_rresp", resp, SLVERR);
    check("rd_to_rdata", data, 32'h0);
    ack_delay = 0;
`endif

    repeat (2) @(negedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
